// File: rtl/mem_stage.sv
// MEM pipeline stage: little-endian byte/half/word data memory feeding the MEM/WB latch.
// Define MEM_ALIGN_CHECK_EN to flag misaligned half/word accesses and suppress their effects.
module mem_stage #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_ADDR = 7
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_MEM_enable,
  input  logic               i_MEM_flush,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic [1:0]         i_MEM_bhw,
  input  logic               i_MEM_unsigned,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_write_data,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB_DATA-1:0] o_debug_data,
  output logic               o_WB_reg_write,
  output logic               o_WB_mem_to_reg,
  output logic [NB_DATA-1:0] o_WB_mem_data,
  output logic [NB_DATA-1:0] o_WB_alu_result,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic               o_MEM_misaligned
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic [NB_DATA-1:0] rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [NB_DATA-1:0] load_data;
  logic [NB_DATA-1:0] wr_data;
  logic [3:0]         byte_en;
  logic               misaligned;
  logic               store_en;
  logic               unused_bits;

  // Address bits above the memory depth are ignored, so addresses wrap.
  assign word_idx     = i_MEM_alu_result[NB_ADDR+1:2];
  assign lane         = i_MEM_alu_result[1:0];
  assign rd_word      = mem[word_idx];
  assign o_debug_data = mem[i_debug_addr];
  assign unused_bits  = &{1'b0, i_MEM_mem_read, i_MEM_alu_result[NB_DATA-1:NB_ADDR+2]};

  always_comb begin
    rd_byte   = rd_word[{lane, 3'b000} +: 8];
    rd_half   = lane[1] ? rd_word[NB_DATA-1:16] : rd_word[15:0];
    load_data = rd_word;
    case (i_MEM_bhw)
      2'b00:   load_data = i_MEM_unsigned ? {{(NB_DATA-8){1'b0}}, rd_byte}
                                          : {{(NB_DATA-8){rd_byte[7]}}, rd_byte};
      2'b01:   load_data = i_MEM_unsigned ? {{(NB_DATA-16){1'b0}}, rd_half}
                                          : {{(NB_DATA-16){rd_half[15]}}, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    byte_en = 4'b1111;
    wr_data = i_MEM_write_data;
    case (i_MEM_bhw)
      2'b00: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{i_MEM_write_data[7:0]}};
      end
      2'b01: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{i_MEM_write_data[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_data = i_MEM_write_data;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if (i_MEM_mem_read || i_MEM_mem_write) begin
      case (i_MEM_bhw)
        2'b00:   misaligned = 1'b0;
        2'b01:   misaligned = lane[0];
        default: misaligned = |lane;
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign store_en = i_MEM_enable && !i_MEM_flush && i_MEM_mem_write && !misaligned;

  always_ff @(posedge i_clock) begin
    if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Flush outranks enable so a bubble can be inserted even while the pipe is stalled.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_WB_reg_write    <= 1'b0;
      o_WB_mem_to_reg   <= 1'b0;
      o_WB_mem_data     <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
      o_MEM_misaligned  <= 1'b0;
    end else if (i_MEM_flush) begin
      o_WB_reg_write    <= 1'b0;
      o_WB_mem_to_reg   <= 1'b0;
      o_WB_mem_data     <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
      o_MEM_misaligned  <= 1'b0;
    end else if (i_MEM_enable) begin
      o_WB_reg_write    <= i_MEM_reg_write && !misaligned;
      o_WB_mem_to_reg   <= i_MEM_mem_to_reg;
      o_WB_mem_data     <= load_data;
      o_WB_alu_result   <= i_MEM_alu_result;
      o_WB_selected_reg <= i_MEM_selected_reg;
      o_MEM_misaligned  <= misaligned;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: byte-addressed reference model checked every cycle plus directed literal checks.
// Compile with MEM_ALIGN_CHECK_EN defined to exercise the alignment-check build.
module tb_mem_stage;

  logic        i_clock;
  logic        i_reset;
  logic        i_MEM_enable;
  logic        i_MEM_flush;
  logic        i_MEM_mem_read;
  logic        i_MEM_mem_write;
  logic        i_MEM_reg_write;
  logic        i_MEM_mem_to_reg;
  logic [1:0]  i_MEM_bhw;
  logic        i_MEM_unsigned;
  logic [31:0] i_MEM_alu_result;
  logic [31:0] i_MEM_write_data;
  logic [4:0]  i_MEM_selected_reg;
  logic [6:0]  i_debug_addr;
  logic [31:0] o_debug_data;
  logic        o_WB_reg_write;
  logic        o_WB_mem_to_reg;
  logic [31:0] o_WB_mem_data;
  logic [31:0] o_WB_alu_result;
  logic [4:0]  o_WB_selected_reg;
  logic        o_MEM_misaligned;

  int checks   = 0;
  int failures = 0;
  logic checking = 1'b0;

  logic [7:0]  bmem [512] = '{default: 8'h00};
  logic        exp_rw, exp_m2r, exp_mis;
  logic [31:0] exp_data, exp_alu;
  logic [4:0]  exp_sel;
  logic [8:0]  m_ba;
  logic        m_mis;

  mem_stage #(.NB_DATA(32), .NB_REG(5), .NB_ADDR(7)) dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_MEM_enable      (i_MEM_enable),
    .i_MEM_flush       (i_MEM_flush),
    .i_MEM_mem_read    (i_MEM_mem_read),
    .i_MEM_mem_write   (i_MEM_mem_write),
    .i_MEM_reg_write   (i_MEM_reg_write),
    .i_MEM_mem_to_reg  (i_MEM_mem_to_reg),
    .i_MEM_bhw         (i_MEM_bhw),
    .i_MEM_unsigned    (i_MEM_unsigned),
    .i_MEM_alu_result  (i_MEM_alu_result),
    .i_MEM_write_data  (i_MEM_write_data),
    .i_MEM_selected_reg(i_MEM_selected_reg),
    .i_debug_addr      (i_debug_addr),
    .o_debug_data      (o_debug_data),
    .o_WB_reg_write    (o_WB_reg_write),
    .o_WB_mem_to_reg   (o_WB_mem_to_reg),
    .o_WB_mem_data     (o_WB_mem_data),
    .o_WB_alu_result   (o_WB_alu_result),
    .o_WB_selected_reg (o_WB_selected_reg),
    .o_MEM_misaligned  (o_MEM_misaligned)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int access_size(input logic [1:0] bhw);
    return (bhw == 2'b00) ? 1 : (bhw == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_misaligned(input logic [8:0] ba, input logic [1:0] bhw, input logic rd, input logic wr);
`ifdef MEM_ALIGN_CHECK_EN
    return (rd || wr) && ((int'(ba) % access_size(bhw)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Loads assemble bytes from the naturally aligned base, least significant byte first.
  function automatic logic [31:0] model_load(input logic [8:0] ba, input logic [1:0] bhw, input logic uns);
    int n;
    int base;
    logic [31:0] v;
    n    = access_size(bhw);
    base = int'(ba) - (int'(ba) % n);
    v    = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(bmem[(base + k) % 512]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [8:0] ba, input logic [1:0] bhw, input logic [31:0] wd);
    int n;
    int base;
    n    = access_size(bhw);
    base = int'(ba) - (int'(ba) % n);
    for (int k = 0; k < n; k++) bmem[(base + k) % 512] = 8'((wd >> (8 * k)) & 32'hFF);
  endtask

  function automatic logic [31:0] model_word(input logic [6:0] a);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < 4; k++) v = v | (32'(bmem[4 * int'(a) + k]) << (8 * k));
    return v;
  endfunction

  // Reference model: load happens before the store of the same edge.
  always @(posedge i_clock or negedge i_reset) begin
    if (!i_reset || i_MEM_flush) begin
      exp_rw   = 1'b0;
      exp_m2r  = 1'b0;
      exp_mis  = 1'b0;
      exp_data = 32'h0;
      exp_alu  = 32'h0;
      exp_sel  = 5'd0;
    end else if (i_MEM_enable) begin
      m_ba     = i_MEM_alu_result[8:0];
      m_mis    = model_misaligned(m_ba, i_MEM_bhw, i_MEM_mem_read, i_MEM_mem_write);
      exp_data = model_load(m_ba, i_MEM_bhw, i_MEM_unsigned);
      if (i_MEM_mem_write && !m_mis) model_store(m_ba, i_MEM_bhw, i_MEM_write_data);
      exp_rw   = i_MEM_reg_write && !m_mis;
      exp_m2r  = i_MEM_mem_to_reg;
      exp_mis  = m_mis;
      exp_alu  = i_MEM_alu_result;
      exp_sel  = i_MEM_selected_reg;
    end
  end

  always @(negedge i_clock) begin
    if (checking) begin
      checkOutput("cyc_reg_write", 32'(o_WB_reg_write), 32'(exp_rw));
      checkOutput("cyc_mem_to_reg", 32'(o_WB_mem_to_reg), 32'(exp_m2r));
      checkOutput("cyc_mem_data", o_WB_mem_data, exp_data);
      checkOutput("cyc_alu_result", o_WB_alu_result, exp_alu);
      checkOutput("cyc_selected_reg", 32'(o_WB_selected_reg), 32'(exp_sel));
      checkOutput("cyc_misaligned", 32'(o_MEM_misaligned), 32'(exp_mis));
      checkOutput("cyc_debug_data", o_debug_data, model_word(i_debug_addr));
    end
  end

  task automatic applyStimulus(input logic en, input logic fl, input logic rd, input logic wr,
                               input logic rw, input logic m2r, input logic [1:0] bhw, input logic uns,
                               input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] sel);
    i_MEM_enable       = en;
    i_MEM_flush        = fl;
    i_MEM_mem_read     = rd;
    i_MEM_mem_write    = wr;
    i_MEM_reg_write    = rw;
    i_MEM_mem_to_reg   = m2r;
    i_MEM_bhw          = bhw;
    i_MEM_unsigned     = uns;
    i_MEM_alu_result   = alu;
    i_MEM_write_data   = wd;
    i_MEM_selected_reg = sel;
    @(posedge i_clock);
    #1;
  endtask

  task automatic peekDebug(input string name, input logic [6:0] a, input logic [31:0] expected);
    i_debug_addr = a;
    #1;
    checkOutput(name, o_debug_data, expected);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset = 1'b0;
    i_debug_addr = 7'd0;
    i_MEM_enable = 1'b0; i_MEM_flush = 1'b0; i_MEM_mem_read = 1'b0; i_MEM_mem_write = 1'b0;
    i_MEM_reg_write = 1'b0; i_MEM_mem_to_reg = 1'b0; i_MEM_bhw = 2'b10; i_MEM_unsigned = 1'b0;
    i_MEM_alu_result = 32'h0; i_MEM_write_data = 32'h0; i_MEM_selected_reg = 5'd0;
    #1;
    checkOutput("rst_reg_write", 32'(o_WB_reg_write), 32'h0);
    checkOutput("rst_mem_data", o_WB_mem_data, 32'h0);
    checkOutput("rst_misaligned", 32'(o_MEM_misaligned), 32'h0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    // The array has no reset, so give every word a known value before checking starts.
    for (int i = 0; i < 128; i++) applyStimulus(1, 0, 0, 1, 0, 0, 2'b10, 0, 32'(i * 4), 32'h0, 5'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 5'd0);
    checking = 1'b1;

    applyStimulus(1, 0, 0, 0, 1, 1, 2'b10, 0, 32'h40, 32'h0, 5'd5);
    checkOutput("pre_reset_reg_write", 32'(o_WB_reg_write), 32'h1);
    #2;
    i_reset = 1'b0;
    #1;
    checkOutput("async_rst_reg_write", 32'(o_WB_reg_write), 32'h0);
    checkOutput("async_rst_mem_to_reg", 32'(o_WB_mem_to_reg), 32'h0);
    checkOutput("async_rst_alu_result", o_WB_alu_result, 32'h0);
    checkOutput("async_rst_selected_reg", 32'(o_WB_selected_reg), 32'h0);
    @(posedge i_clock);
    #1;
    i_reset = 1'b1;

    applyStimulus(1, 0, 0, 1, 0, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd0);
    applyStimulus(1, 0, 1, 0, 1, 1, 2'b10, 0, 32'h10, 32'h0, 5'd3);
    checkOutput("word_load", o_WB_mem_data, 32'hDEADBEEF);
    peekDebug("debug_word4", 7'd4, 32'hDEADBEEF);

    applyStimulus(1, 0, 0, 1, 0, 0, 2'b10, 0, 32'h10, 32'h0, 5'd0);
    applyStimulus(1, 0, 0, 1, 0, 0, 2'b00, 0, 32'h13, 32'hABCDEF80, 5'd0);
    peekDebug("byte_store", 7'd4, 32'h80000000);
    applyStimulus(1, 0, 1, 0, 1, 1, 2'b00, 0, 32'h13, 32'h0, 5'd4);
    checkOutput("byte_load_signed", o_WB_mem_data, 32'hFFFFFF80);
    applyStimulus(1, 0, 1, 0, 1, 1, 2'b00, 1, 32'h13, 32'h0, 5'd4);
    checkOutput("byte_load_unsigned", o_WB_mem_data, 32'h00000080);

    applyStimulus(1, 0, 0, 1, 0, 0, 2'b01, 0, 32'h22, 32'h55558001, 5'd0);
    peekDebug("half_store", 7'd8, 32'h80010000);
    applyStimulus(1, 0, 1, 0, 1, 1, 2'b01, 0, 32'h22, 32'h0, 5'd9);
    checkOutput("half_load_signed", o_WB_mem_data, 32'hFFFF8001);

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1, 0, 2'b10, 0, 32'h20, 32'h11111111, 5'd7);
    checkOutput("hold_mem_data", o_WB_mem_data, 32'hFFFF8001);
    checkOutput("hold_selected_reg", 32'(o_WB_selected_reg), 32'd9);
    peekDebug("hold_no_store", 7'd8, 32'h80010000);
    applyStimulus(1, 1, 0, 1, 1, 1, 2'b10, 0, 32'h20, 32'h22222222, 5'd4);
    checkOutput("flush_reg_write", 32'(o_WB_reg_write), 32'h0);
    checkOutput("flush_selected_reg", 32'(o_WB_selected_reg), 32'h0);
    peekDebug("flush_no_store", 7'd8, 32'h80010000);

    applyStimulus(1, 0, 1, 1, 1, 1, 2'b10, 0, 32'h30, 32'hAAAA5555, 5'd6);
    checkOutput("rd_wr_old_data", o_WB_mem_data, 32'h0);
    peekDebug("rd_wr_store", 7'd12, 32'hAAAA5555);
    applyStimulus(1, 0, 1, 0, 1, 1, 2'b10, 0, 32'h30, 32'h0, 5'd6);

    applyStimulus(1, 0, 0, 1, 0, 0, 2'b10, 0, 32'h40, 32'h7F8001FF, 5'd0);
    for (int l = 0; l < 4; l++)
      for (int u = 0; u < 2; u++) applyStimulus(1, 0, 1, 0, 1, 1, 2'b00, u[0], 32'(32'h40 + l), 32'h0, 5'd1);
    for (int l = 0; l < 2; l++)
      for (int u = 0; u < 2; u++) applyStimulus(1, 0, 1, 0, 1, 1, 2'b01, u[0], 32'(32'h40 + 2 * l), 32'h0, 5'd2);
    applyStimulus(1, 0, 1, 0, 1, 1, 2'b00, 0, 32'h40, 32'h0, 5'd1);
    checkOutput("byte_lane0_signed", o_WB_mem_data, 32'hFFFFFFFF);
    applyStimulus(1, 0, 1, 0, 1, 1, 2'b01, 1, 32'h42, 32'h0, 5'd2);
    checkOutput("half_upper_unsigned", o_WB_mem_data, 32'h00007F80);
    applyStimulus(1, 0, 1, 0, 1, 1, 2'b10, 0, 32'hFFFFFE40, 32'h0, 5'd2);
    checkOutput("addr_wrap_load", o_WB_mem_data, 32'h7F8001FF);

    applyStimulus(1, 0, 0, 1, 1, 0, 2'b10, 0, 32'h02, 32'h12345678, 5'd3);
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("misalign_flag", 32'(o_MEM_misaligned), 32'h1);
    checkOutput("misalign_reg_write", 32'(o_WB_reg_write), 32'h0);
    peekDebug("misalign_no_store", 7'd0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 5'd0);
    checkOutput("misalign_flag_held", 32'(o_MEM_misaligned), 32'h1);
`else
    checkOutput("misalign_flag", 32'(o_MEM_misaligned), 32'h0);
    checkOutput("misalign_reg_write", 32'(o_WB_reg_write), 32'h1);
    peekDebug("misalign_store", 7'd0, 32'h12345678);
`endif
    applyStimulus(1, 0, 1, 0, 0, 0, 2'b01, 1, 32'h03, 32'h0, 5'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 2'b10, 0, 32'h0, 32'h0, 5'd0);
    @(negedge i_clock);
    #1;
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM pipeline stage plus MEM/WB pipeline latch: sits between the EX/MEM latch and the write-back stage.
- Performs data-memory loads/stores (byte/half/word, little-endian) with sign or zero extension.
- Registers results and WB control (reg_write, mem_to_reg, mem_data, alu_result, selected_reg) for the write-back mux.
- Debug read port lets the debug unit dump data memory.

Parameters:
NB_DATA, 32, data/word width
NB_REG, 5, register-index width
NB_ADDR, 7, word-address width (memory depth 2^NB_ADDR words)

Ports:
i_clock  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_MEM_enable  input  1  pipeline advance (0 = hold; debug step/halt)
i_MEM_flush  input  1  insert bubble into MEM/WB latch
i_MEM_mem_read  input  1  load request
i_MEM_mem_write  input  1  store request
i_MEM_reg_write  input  1  WB control passthrough
i_MEM_mem_to_reg  input  1  WB control passthrough
i_MEM_bhw  input  2  00 byte, 01 half, 10/11 word
i_MEM_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend
i_MEM_alu_result  input  NB_DATA  byte address / ALU result
i_MEM_write_data  input  NB_DATA  store data (rt)
i_MEM_selected_reg  input  NB_REG  destination register
i_debug_addr  input  NB_ADDR  debug word address
o_debug_data  output  NB_DATA  combinational memory word at i_debug_addr
o_WB_reg_write  output  1  registered
o_WB_mem_to_reg  output  1  registered
o_WB_mem_data  output  NB_DATA  registered, extended load data
o_WB_alu_result  output  NB_DATA  registered
o_WB_selected_reg  output  NB_REG  registered
o_MEM_misaligned  output  1  registered misalignment flag (see Optional Feature)

Behaviour:
- Reset (i_reset=0, async): all o_WB_* and o_MEM_misaligned = 0 immediately. Memory array is not reset; simulation initialises it to zero.
- Word index = alu_result[NB_ADDR+1:2]; byte lane = alu_result[1:0]; upper address bits ignored (wrap).
- Store, on rising edge when enable=1, flush=0, mem_write=1:
  - byte: data[7:0] written to lane addr[1:0].
  - half: data[15:0] written to lanes {addr[1],1}:{addr[1],0}.
  - word: all four lanes written.
  - Other lanes are unchanged.
- Load: combinational read of the indexed word. Lane extraction as for stores. Extended to NB_DATA per i_MEM_unsigned. Result captured in the latch.
- Load latency: 1 cycle (data visible on o_WB_mem_data the cycle after the MEM-stage inputs).
- When mem_read=0, o_WB_mem_data still latches the extracted value; WB ignores it when mem_to_reg=0.
- Same-edge store and load to the same word: latch captures the old contents (read-before-write).
- enable=0, flush=0: latch holds all values; no store occurs.
- flush=1 (priority over enable): latch loads reg_write=0, mem_to_reg=0, selected_reg=0, data=0, misaligned=0; store suppressed.
- mem_read and mem_write both 1: store performed; loaded value is old contents.
- o_debug_data is a purely combinational read, independent of enable.

Optional Feature:
Macro MEM_ALIGN_CHECK_EN.
- Defined: half access with addr[0]=1, or word access with addr[1:0]!=0, while mem_read or mem_write = 1, is misaligned. Consequences:
  - store suppressed;
  - latched reg_write forced to 0;
  - o_MEM_misaligned=1 for that latched cycle (held while enable=0).
- Undefined: o_MEM_misaligned tied 0. Half ignores addr[0]; word ignores addr[1:0].

Test Plan:
1. Reset mid-operation: assert i_reset=0 with o_WB_reg_write=1 -> all o_WB_* go 0 without a clock edge.
2. Word store 0xDEADBEEF at addr 0x10, then word load addr 0x10 -> next cycle o_WB_mem_data=0xDEADBEEF; o_debug_data at index 4 = 0xDEADBEEF.
3. Byte store 0x80 at addr 0x13 over word 0 -> word=0x80000000. Signed byte load at 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080.
4. Half store 0x8001 at addr 0x22 -> word index 8 upper half=0x8001. Signed half load -> 0xFFFF8001.
5. enable=0 for 3 cycles with mem_write=1 -> latch holds, memory unchanged. flush=1 with reg_write=1 -> o_WB_reg_write=0, store suppressed.
6. MEM_ALIGN_CHECK_EN defined: word store at 0x02 -> memory unchanged, o_MEM_misaligned=1, o_WB_reg_write=0. Undefined: writes word index 0, flag 0.
